// File: rtl/cycpuf_pkg.sv
// Shared types and defaults for the cyclic RO PUF measurement engine.
package cycpuf_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_WINDOW     = 1024;
  localparam int TMV_ROUNDS     = 3;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/cycpuf_edge_counter.sv
// One RO channel: 2-FF synchroniser, rising-edge detect, saturating counter.
module cycpuf_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // [1:0] synchroniser stages, [2] previous synchronised sample
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
    end else begin
      sync <= {sync[1:0], ro};
      if (clr) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (en && rise) begin
        // an edge arriving at full scale is lost, so flag the count as clipped
        if (&cnt) sat <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cycpuf_eval_engine.sv
// Parametrised cyclic RO PUF evaluation engine with valid/ready response.
// Optional triple-round majority voting: define CYCPUF_TMV_EN.
module cycpuf_eval_engine import cycpuf_pkg::*; #(
  parameter int NUM_BITS   = 4,
  parameter int SEL_W      = 1,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WINDOW     = DEF_WINDOW
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [2*SEL_W-1:0]              chal,
  input  logic [NUM_BITS*2*(2**SEL_W)-1:0] ro_in,
  output logic                            ro_en,
  output logic                            busy,
  output logic [NUM_BITS-1:0]             resp,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [NUM_BITS-1:0]             tie,
  output logic                            sat
);

  localparam int NRO = 2**SEL_W;
  localparam int TW  = $clog2((SETTLE_CYC > WINDOW ? SETTLE_CYC : WINDOW) + 1);

  state_t                           state;
  logic [TW-1:0]                    timer;
  logic [2*SEL_W-1:0]               chal_q;
  logic [NUM_BITS-1:0][CNT_W-1:0]   cnt_a, cnt_b;
  logic [NUM_BITS-1:0]              sat_a, sat_b, gt, eq;
  logic                             cnt_en, cnt_clr, cnt_sat, last_round;

`ifdef CYCPUF_TMV_EN
  localparam int NROUNDS = TMV_ROUNDS;
  logic [1:0]                       round;
  logic [1:0][NUM_BITS-1:0]         votes;
  logic [NUM_BITS-1:0]              tie_acc;
  logic                             sat_acc;
  assign last_round = (round == 2'(NROUNDS-1));
`else
  assign last_round = 1'b1;
`endif

  assign cnt_en  = (state == MEASURE);
  assign cnt_clr = (state == IDLE) || (state == COMPARE);
  assign cnt_sat = |{sat_a, sat_b};

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    logic [NRO-1:0]   grp_a, grp_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    assign grp_a = ro_in[i*2*NRO +: NRO];
    assign grp_b = ro_in[i*2*NRO+NRO +: NRO];
    // odd bits take the challenge halves crosswise
    if (i % 2 == 0) begin : g_even
      assign sel_a = chal_q[SEL_W-1:0];
      assign sel_b = chal_q[2*SEL_W-1:SEL_W];
    end else begin : g_odd
      assign sel_a = chal_q[2*SEL_W-1:SEL_W];
      assign sel_b = chal_q[SEL_W-1:0];
    end
    cycpuf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk(clk), .reset(reset), .ro(grp_a[sel_a]), .clr(cnt_clr), .en(cnt_en),
      .cnt(cnt_a[i]), .sat(sat_a[i]));
    cycpuf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk(clk), .reset(reset), .ro(grp_b[sel_b]), .clr(cnt_clr), .en(cnt_en),
      .cnt(cnt_b[i]), .sat(sat_b[i]));
  end

  always_comb begin
    gt = '0;
    eq = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      gt[i] = cnt_a[i] > cnt_b[i];
      eq[i] = cnt_a[i] == cnt_b[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      chal_q     <= '0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
      tie        <= '0;
      sat        <= 1'b0;
`ifdef CYCPUF_TMV_EN
      round      <= '0;
      votes      <= '0;
      tie_acc    <= '0;
      sat_acc    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          chal_q <= chal;
          busy   <= 1'b1;
          // first settle gets one extra cycle: the bank only starts after ro_en rises
          timer  <= TW'(SETTLE_CYC);
          state  <= SETTLE;
`ifdef CYCPUF_TMV_EN
          round   <= '0;
          tie_acc <= '0;
          sat_acc <= 1'b0;
`endif
        end
        SETTLE: begin
          ro_en <= 1'b1;
          if (timer == '0) begin
            timer <= TW'(WINDOW-1);
            state <= MEASURE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        MEASURE: begin
          if (timer == '0) begin
            if (last_round) ro_en <= 1'b0;
            state <= COMPARE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        COMPARE: begin
`ifdef CYCPUF_TMV_EN
          if (!last_round) begin
            votes[round[0]] <= gt;
            tie_acc         <= tie_acc | eq;
            sat_acc         <= sat_acc | cnt_sat;
            round           <= round + 1'b1;
            timer           <= TW'(SETTLE_CYC-1);
            state           <= SETTLE;
          end else begin
            for (int i = 0; i < NUM_BITS; i++)
              resp[i] <= maj3({gt[i], votes[1][i], votes[0][i]});
            tie        <= tie_acc | eq;
            sat        <= sat_acc | cnt_sat;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
`else
          resp       <= gt;
          tie        <= eq;
          sat        <= cnt_sat;
          resp_valid <= 1'b1;
          state      <= DONE;
`endif
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cycpuf_eval_engine.md
Name: cycpuf_eval_engine

Overview:
- Parametrised measurement engine for the cyclic RO PUF; generalises the fixed 2-bit, 8-RO cycropuf top.
- Takes NUM_BITS response bits. Each bit compares two challenge-selected ring oscillators from an external RO bank.
- Edge counting is done in the system clock domain over a programmable window. The result is returned through a valid/ready handshake.
- Sits between the RO bank and the challenge/response host interface.

Parameters:
- NUM_BITS, 4: number of response bits (pairs of muxes).
- SEL_W, 1: select bits per mux; each mux chooses among 2**SEL_W ROs.
- CNT_W, 16: edge-counter width (saturating).
- SETTLE_CYC, 16: clk cycles ROs run before counting starts.
- WINDOW, 1024: clk cycles of counting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request evaluation; sampled only in IDLE.
- chal  in  2*SEL_W  challenge; latched when start is accepted.
- ro_in  in  NUM_BITS*2*2**SEL_W  RO outputs, asynchronous to clk.
  - Bit i, side A uses slice base i*2*2**SEL_W.
  - Side B follows side A.
- ro_en  out  1  RO bank enable.
- busy  out  1  high in any state other than IDLE.
- resp  out  NUM_BITS  response; valid while resp_valid is high.
- resp_valid  out  1  response available.
- resp_ready  in  1  host accepts response.
- tie  out  NUM_BITS  per-bit equal-count flag.
- sat  out  1  any counter saturated during the window.

Behaviour:
- Reset (async): state IDLE; ro_en, busy, resp, resp_valid, tie, sat = 0; challenge register and counters cleared.
- Challenge select, for even bit i:
  - Side A select = chal[SEL_W-1:0].
  - Side B select = chal[2*SEL_W-1:SEL_W].
- Odd bits swap the two halves (crosswise, as in the cyclic topology).
- Each selected RO passes through a 2-FF synchroniser, then a rising-edge detector.
- RO frequency must be below clk/2; the RO bank divides as needed.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE:
  - start=1 at edge T → latch chal, clear counters, go SETTLE.
  - ro_en rises at T+1.
- SETTLE:
  - Runs SETTLE_CYC cycles; edges are not counted.
  - Then go MEASURE.
- MEASURE:
  - Runs exactly WINDOW cycles.
  - Each detected edge increments its counter by 1.
  - Counters saturate at 2**CNT_W-1; saturation sets the sticky sat flag.
- COMPARE:
  - One cycle; ro_en drops at entry.
  - resp[i] = (cntA[i] > cntB[i]).
  - tie[i] = (cntA[i] == cntB[i]); a tie gives resp[i] = 0.
- DONE:
  - resp_valid rises at edge T+SETTLE_CYC+WINDOW+2.
  - resp, tie and sat are held stable while resp_valid && !resp_ready.
  - Handshake (resp_valid && resp_ready) → IDLE next edge; resp_valid=0, busy=0.
  - start is ignored in the handshake cycle.
- start outside IDLE: ignored; no queuing.
- chal changes after acceptance: no effect.
- Reset mid-operation: immediate IDLE, ro_en=0, no partial response.

Optional Feature:
- Macro: CYCPUF_TMV_EN.
- When defined:
  - Runs three SETTLE/MEASURE/COMPARE rounds back to back.
  - resp[i] = 2-of-3 majority of per-round bits.
  - tie[i] = OR of per-round ties.
  - sat = OR over all rounds.
  - Counters are cleared between rounds; ro_en stays high between rounds.
  - resp_valid at T+3*(SETTLE_CYC+WINDOW+1)+1.
- When undefined: single round as above.

Decomposition:
- Package cycpuf_pkg holds:
  - state enum (IDLE, SETTLE, MEASURE, COMPARE, DONE);
  - default constants for CNT_W, SETTLE_CYC, WINDOW;
  - round-count constant (3) used by the TMV option.
- Sub-module cycpuf_edge_counter contains the 2-FF synchroniser, edge detector, saturating CNT_W counter with clear/enable, and sat output.
- 2*NUM_BITS instances of cycpuf_edge_counter.

Test Plan (NUM_BITS=2, SEL_W=1, SETTLE_CYC=4, WINDOW=64, CNT_W=16 unless noted):
- chal=2'b00; side A RO period 4 clk (16 edges), side B period 8 (8 edges) → resp[0]=1, tie=0, sat=0; resp_valid at T+70.
- Swap periods (A=8, B=4) with chal=2'b01 → resp bit(s) = 0; confirm the odd bit uses swapped select halves.
- Identical period 8 on both sides → resp=0, tie=2'b11.
- CNT_W=4, both sides period 2 → counts 15/15, sat=1, tie=2'b11.
- Hold resp_ready=0 for 20 cycles after resp_valid; pulse start during the wait → outputs stable, no new evaluation; ready=1 → IDLE next edge.
- Assert reset at cycle 30 of MEASURE → ro_en=0, busy=0 immediately; a fresh start then gives a correct result. With CYCPUF_TMV_EN, force round 2 to disagree → majority result, resp_valid at T+208.
